// File: rtl/hh_neuron_pkg.sv
// Shared constants and types for the HH neuron output path.
// The spike detector and its event FIFO use these definitions.
package hh_neuron_pkg;

    localparam int V_W   = 16;
    localparam int TS_W  = 16;
    localparam int EVT_W = TS_W + V_W;

    typedef enum logic [1:0] {
        BELOW  = 2'd0,
        ABOVE  = 2'd1,
        REFRAC = 2'd2
    } det_state_t;

endpackage

// File: rtl/hh_evt_fifo.sv
// Small synchronous event FIFO with registered storage.
// The head output holds the last popped value while the FIFO is empty.
module hh_evt_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] last_q;
    logic [AW:0]  wp;
    logic [AW:0]  rp;
    logic         wr_en;
    logic         rd_en;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rd_en = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en = push && (!full || rd_en);
    assign dout  = empty ? last_q : mem[rp[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp     <= '0;
            rp     <= '0;
            last_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wp[AW-1:0]] <= din;
                wp              <= wp + 1'b1;
            end
            if (rd_en) begin
                last_q <= mem[rp[AW-1:0]];
                rp     <= rp + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hh_spike_detector.sv
// Threshold spike detector with hysteresis and refractory window.
// Emits {rise timestamp, peak voltage} per spike through an event FIFO.
module hh_spike_detector
    import hh_neuron_pkg::*;
#(
    parameter int V_W        = hh_neuron_pkg::V_W,
    parameter int TS_W       = hh_neuron_pkg::TS_W,
    parameter int REFRAC_CYC = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            v_valid,
    input  logic [V_W-1:0]  v_in,
    input  logic [V_W-1:0]  vth_hi,
    input  logic [V_W-1:0]  vth_lo,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [TS_W-1:0] evt_ts,
    output logic [V_W-1:0]  evt_peak,
    output logic [15:0]     spike_cnt,
    output logic            ovf,
    input  logic            clr_ovf
);

    localparam int EW = TS_W + V_W;
    localparam int RW = $clog2(REFRAC_CYC + 1);

    det_state_t      state;
    det_state_t      state_n;
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] rise_ts;
    logic [V_W-1:0]  peak;
    logic [V_W-1:0]  peak_max;
    logic [RW-1:0]   rcnt;
    logic            hi;
    logic            lo;
    logic            rise;
    logic            track;
    logic            push;
    logic            rload;
    logic            rdec;
    logic            full;
    logic            empty;
    logic            pop;
    logic [EW-1:0]   head;

    assign hi       = $signed(v_in) >= $signed(vth_hi);
    assign lo       = $signed(v_in) <= $signed(vth_lo);
    assign peak_max = ($signed(v_in) > $signed(peak)) ? v_in : peak;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BELOW;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        rise    = 1'b0;
        track   = 1'b0;
        push    = 1'b0;
        rload   = 1'b0;
        rdec    = 1'b0;
        if (v_valid) begin
            unique case (state)
                BELOW: begin
                    if (hi) begin
                        state_n = ABOVE;
                        rise    = 1'b1;
                    end
                end
                ABOVE: begin
                    track = 1'b1;
                    if (lo) begin
                        state_n = REFRAC;
                        push    = 1'b1;
                        rload   = 1'b1;
                    end
                end
                REFRAC: begin
                    rdec = 1'b1;
                    if (rcnt == RW'(1)) begin
                        state_n = BELOW;
                    end
                end
                default: state_n = BELOW;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts        <= '0;
            rise_ts   <= '0;
            peak      <= '0;
            rcnt      <= '0;
            spike_cnt <= '0;
            ovf       <= 1'b0;
        end else begin
            ts <= ts + 1'b1;
            if (rise) begin
                rise_ts <= ts;
                peak    <= v_in;
                if (spike_cnt != 16'hFFFF) begin
                    spike_cnt <= spike_cnt + 16'd1;
                end
            end
            if (track) begin
                peak <= peak_max;
            end
            if (rload) begin
                rcnt <= RW'(REFRAC_CYC);
            end else if (rdec) begin
                rcnt <= rcnt - 1'b1;
            end
            // Set beats clear when both happen together.
            if (push && full && !pop) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    assign evt_valid = !empty;
    assign pop       = evt_valid && evt_ready;
    assign evt_ts    = head[EW-1:V_W];
    assign evt_peak  = head[V_W-1:0];

    hh_evt_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({rise_ts, peak_max}),
        .full  (full),
        .pop   (pop),
        .dout  (head),
        .empty (empty)
    );

endmodule

// File: tb/tb_hh_spike_detector.sv
// Directed bench for hh_spike_detector, plus a narrow-timestamp instance.
// Inputs change on negedge; outputs are checked on negedge.
module tb_hh_spike_detector;

    logic        clk = 1'b0;
    logic        reset;
    logic        v_valid;
    logic [15:0] v_in;
    logic [15:0] vth_hi;
    logic [15:0] vth_lo;
    logic        evt_valid;
    logic        evt_ready;
    logic [15:0] evt_ts;
    logic [15:0] evt_peak;
    logic [15:0] spike_cnt;
    logic        ovf;
    logic        clr_ovf;

    logic        w_reset;
    logic        w_valid;
    logic [15:0] w_v;
    logic        w_evt_valid;
    logic [3:0]  w_evt_ts;
    logic [15:0] w_evt_peak;
    logic [15:0] w_cnt;
    logic        w_ovf;

    int          errs = 0;
    int          checks = 0;
    logic [15:0] tb_ts;
    logic [15:0] rts [6];
    logic [15:0] rts2 [5];

    always #5 clk = ~clk;

    hh_spike_detector u_dut (
        .clk       (clk),
        .reset     (reset),
        .v_valid   (v_valid),
        .v_in      (v_in),
        .vth_hi    (vth_hi),
        .vth_lo    (vth_lo),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ts    (evt_ts),
        .evt_peak  (evt_peak),
        .spike_cnt (spike_cnt),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    hh_spike_detector #(
        .TS_W       (4),
        .REFRAC_CYC (1)
    ) u_wrap (
        .clk       (clk),
        .reset     (w_reset),
        .v_valid   (w_valid),
        .v_in      (w_v),
        .vth_hi    (vth_hi),
        .vth_lo    (vth_lo),
        .evt_valid (w_evt_valid),
        .evt_ready (1'b1),
        .evt_ts    (w_evt_ts),
        .evt_peak  (w_evt_peak),
        .spike_cnt (w_cnt),
        .ovf       (w_ovf),
        .clr_ovf   (clr_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        tb_ts = tb_ts + 16'd1;
        @(negedge clk);
    endtask

    task automatic smp(input logic [15:0] v);
        v_valid = 1'b1;
        v_in    = v;
        tick();
        v_valid = 1'b0;
    endtask

    task automatic refrac();
        for (int i = 0; i < 8; i++) smp(16'd0);
    endtask

    initial begin
        reset     = 1'b1;
        w_reset   = 1'b1;
        v_valid   = 1'b0;
        v_in      = '0;
        w_valid   = 1'b0;
        w_v       = '0;
        vth_hi    = 16'd100;
        vth_lo    = -16'sd50;
        evt_ready = 1'b1;
        clr_ovf   = 1'b0;
        tb_ts     = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_ts", 32'(evt_ts), 32'd0);
        chk("rst_peak", 32'(evt_peak), 32'd0);
        chk("rst_cnt", 32'(spike_cnt), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // single spike: rise sample lands at ts=7
        reset = 1'b0;
        tb_ts = '0;
        repeat (5) tick();
        smp(-16'sd100);
        smp(16'd0);
        smp(16'd120);
        chk("s1_cnt", 32'(spike_cnt), 32'd1);
        smp(16'd300);
        smp(16'd80);
        chk("s1_novalid", 32'(evt_valid), 32'd0);
        smp(-16'sd60);
        chk("s1_valid", 32'(evt_valid), 32'd1);
        chk("s1_ts", 32'(evt_ts), 32'd7);
        chk("s1_peak", 32'(evt_peak), 32'd300);
        tick();
        chk("s1_popped", 32'(evt_valid), 32'd0);
        chk("s1_hold_ts", 32'(evt_ts), 32'd7);

        // refractory, with a v_valid gap that must not advance rcnt
        for (int i = 1; i <= 9; i++) begin
            if (i == 6) tick();
            if (i == 9) rts[0] = tb_ts;
            smp((i == 3 || i == 9) ? 16'd200 : 16'd0);
            if (i == 8) chk("rf_cnt_hold", 32'(spike_cnt), 32'd1);
        end
        chk("rf_cnt", 32'(spike_cnt), 32'd2);
        smp(-16'sd60);
        chk("rf_valid", 32'(evt_valid), 32'd1);
        chk("rf_ts", 32'(evt_ts), 32'(rts[0]));
        chk("rf_peak", 32'(evt_peak), 32'd200);
        tick();
        refrac();

        // hysteresis
        rts[0] = tb_ts;
        smp(16'd120);
        smp(16'd90);
        smp(16'd120);
        smp(16'd90);
        chk("hy_novalid", 32'(evt_valid), 32'd0);
        chk("hy_cnt", 32'(spike_cnt), 32'd3);
        smp(-16'sd60);
        chk("hy_valid", 32'(evt_valid), 32'd1);
        chk("hy_ts", 32'(evt_ts), 32'(rts[0]));
        chk("hy_peak", 32'(evt_peak), 32'd120);
        tick();
        refrac();

        // backpressure: 6 spikes into a 4-deep FIFO
        evt_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rts[i] = tb_ts;
            smp(16'(150 + i));
            smp(-16'sd60);
            refrac();
        end
        chk("bp_ovf", 32'(ovf), 32'd1);
        chk("bp_cnt", 32'(spike_cnt), 32'd9);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("bp_clr", 32'(ovf), 32'd0);
        chk("bp_peak0", 32'(evt_peak), 32'd150);
        for (int i = 0; i < 4; i++) begin
            chk("bp_dvalid", 32'(evt_valid), 32'd1);
            chk("bp_dts", 32'(evt_ts), 32'(rts[i]));
            evt_ready = 1'b1;
            tick();
            evt_ready = 1'b0;
        end
        chk("bp_empty", 32'(evt_valid), 32'd0);

        // full FIFO with push and pop together
        for (int i = 0; i < 5; i++) begin
            rts2[i] = tb_ts;
            smp(16'd160);
            if (i == 4) evt_ready = 1'b1;
            smp(-16'sd60);
            evt_ready = 1'b0;
            if (i < 4) refrac();
        end
        chk("fp_ovf", 32'(ovf), 32'd0);
        for (int i = 1; i < 5; i++) begin
            chk("fp_dvalid", 32'(evt_valid), 32'd1);
            chk("fp_dts", 32'(evt_ts), 32'(rts2[i]));
            evt_ready = 1'b1;
            tick();
            evt_ready = 1'b0;
        end
        chk("fp_empty", 32'(evt_valid), 32'd0);
        refrac();

        // async reset mid-ABOVE with a queued event
        smp(16'd130);
        smp(-16'sd60);
        refrac();
        smp(16'd140);
        chk("ar_pre_valid", 32'(evt_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", 32'(evt_valid), 32'd0);
        chk("ar_cnt", 32'(spike_cnt), 32'd0);
        chk("ar_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tb_ts = '0;
        smp(16'd200);
        chk("ar_cnt1", 32'(spike_cnt), 32'd1);
        evt_ready = 1'b1;
        smp(-16'sd60);
        chk("ar_evalid", 32'(evt_valid), 32'd1);
        chk("ar_ets", 32'(evt_ts), 32'd0);
        chk("ar_epeak", 32'(evt_peak), 32'd200);
        tick();

        // 4-bit timestamp wrap, refractory of one sample
        w_reset = 1'b0;
        repeat (15) tick();
        w_valid = 1'b1;
        w_v     = 16'd120;
        tick();
        w_v     = -16'sd60;
        tick();
        chk("wr_valid1", 32'(w_evt_valid), 32'd1);
        chk("wr_ts1", 32'(w_evt_ts), 32'd15);
        w_v     = 16'd0;
        tick();
        w_v     = 16'd120;
        tick();
        w_v     = -16'sd60;
        tick();
        w_valid = 1'b0;
        chk("wr_valid2", 32'(w_evt_valid), 32'd1);
        chk("wr_ts2", 32'(w_evt_ts), 32'd2);
        chk("wr_cnt", 32'(w_cnt), 32'd2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
